// File: rtl/ultrasonic_ranger_pkg.sv
// Shared types and helpers for the ultrasonic ranger: FSM encodings,
// sample classes and the width classifier used by the hysteresis logic.
package ultrasonic_ranger_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_TRIG      = 3'd1;
   localparam logic [2:0] ST_WAIT_RISE = 3'd2;
   localparam logic [2:0] ST_MEASURE   = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

   // Round-trip echo time per centimetre of range.
   localparam int unsigned US_PER_CM = 58;

   typedef enum logic [1:0] {
      CLS_NEUTRAL = 2'd0,
      CLS_CLOSE   = 2'd1,
      CLS_CLEAR   = 2'd2
   } sample_cls_t;

   // Timeouts and saturated echoes carry no usable range and count as clear.
   function automatic sample_cls_t classify(input logic [15:0] width,
                                            input logic [15:0] close_us,
                                            input logic [15:0] clear_us,
                                            input logic        force_clear);
      if (force_clear || (width > clear_us)) begin
         return CLS_CLEAR;
      end
      if (width < close_us) begin
         return CLS_CLOSE;
      end
      return CLS_NEUTRAL;
   endfunction

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Sensor pins plus the range/status outputs of the ranger; master is the
// ranger itself, slave is the sensor/motor/debug side that observes it.
interface ultrasonic_ranger_if;

   logic        enable;
   logic        echo;
   logic        trig;
   logic        tooClose;
   logic [15:0] echo_us;
   logic        sample_valid;
   logic        timeout_err;

   modport master (
      input  enable,
      input  echo,
      output trig,
      output tooClose,
      output echo_us,
      output sample_valid,
      output timeout_err
   );

   modport slave (
      output enable,
      output echo,
      input  trig,
      input  tooClose,
      input  echo_us,
      input  sample_valid,
      input  timeout_err
   );

endinterface

// File: rtl/ultrasonic_ranger_us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CLK_HZ/1e6 clocks, free-running
// from reset release; a 1 MHz (or slower) clock yields a tick on every cycle.
module ultrasonic_ranger_us_tick_gen #(
   parameter int unsigned CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned DIV = (CLK_HZ >= 2_000_000) ? (CLK_HZ / 1_000_000) : 1;
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      tick  = (cnt_q == CW'(DIV - 1));
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo width in us, and a debounced
// tooClose flag with close/clear hysteresis for the downstream motor stage.
module ultrasonic_ranger
   import ultrasonic_ranger_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 100_000_000,
   parameter int unsigned TRIG_US         = 10,
   parameter int unsigned PERIOD_US       = 60000,
   parameter int unsigned RISE_TIMEOUT_US = 5000,
   parameter int unsigned MAX_ECHO_US     = 25000,
   parameter int unsigned CLOSE_US        = 1160,
   parameter int unsigned CLEAR_US        = 1450,
   parameter int unsigned CONFIRM         = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   ultrasonic_ranger_if.master io
);

   localparam logic [15:0] TRIG_W    = TRIG_US[15:0];
   localparam logic [15:0] PERIOD_W  = PERIOD_US[15:0];
   localparam logic [15:0] RISE_W    = RISE_TIMEOUT_US[15:0];
   localparam logic [15:0] MAX_W     = MAX_ECHO_US[15:0];
   localparam logic [15:0] CLOSE_W   = CLOSE_US[15:0];
   localparam logic [15:0] CLEAR_W   = CLEAR_US[15:0];
   localparam logic [3:0]  CONFIRM_W = CONFIRM[3:0];

   logic us_tick;

   ultrasonic_ranger_us_tick_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (us_tick)
   );

   logic        echo_s1_q, echo_s1_d;
   logic        echo_s2_q, echo_s2_d;
   logic        echo_s3_q, echo_s3_d;
   logic [2:0]  state_q, state_d;
   logic        first_q, first_d;
   logic [15:0] period_q, period_d;
   logic [15:0] phase_q, phase_d;
   logic [15:0] width_q, width_d;
   logic        sat_q, sat_d;
   logic        tmo_q, tmo_d;
   logic        sampled_q, sampled_d;
   logic [3:0]  agree_q, agree_d;
   logic        too_close_q, too_close_d;
   logic [15:0] echo_us_q, echo_us_d;
   logic        valid_q, valid_d;
   logic        timeout_err_q, timeout_err_d;

   logic        echo_rise;
   logic [15:0] period_inc;
   logic [15:0] phase_inc;
   logic [15:0] width_inc;
   logic [3:0]  agree_inc;
   sample_cls_t cls;
   logic        opposing;
   logic        agreeing;

   always_comb begin
      echo_s1_d  = io.echo;
      echo_s2_d  = echo_s1_q;
      echo_s3_d  = echo_s2_q;
      echo_rise  = echo_s2_q & ~echo_s3_q;

      period_inc = (period_q == 16'hFFFF) ? period_q : period_q + 16'd1;
      phase_inc  = phase_q + 16'd1;
      width_inc  = width_q + 16'd1;
      agree_inc  = agree_q + 4'd1;

      cls      = classify(width_q, CLOSE_W, CLEAR_W, tmo_q | sat_q);
      opposing = too_close_q ? (cls == CLS_CLEAR) : (cls == CLS_CLOSE);
      agreeing = too_close_q ? (cls == CLS_CLOSE) : (cls == CLS_CLEAR);

      state_d       = state_q;
      first_d       = first_q;
      period_d      = period_q;
      phase_d       = phase_q;
      width_d       = width_q;
      sat_d         = sat_q;
      tmo_d         = tmo_q;
      sampled_d     = sampled_q;
      agree_d       = agree_q;
      too_close_d   = too_close_q;
      echo_us_d     = echo_us_q;
      valid_d       = 1'b0;
      timeout_err_d = timeout_err_q;

      // Period counter includes the current tick, so PERIOD_US ticks after a
      // trigger rise the next one starts.
      if (us_tick) begin
         period_d = period_inc;
      end

      case (state_q)
         ST_IDLE: begin
            if (us_tick && io.enable && (first_q || (period_inc >= PERIOD_W))) begin
               state_d  = ST_TRIG;
               first_d  = 1'b0;
               period_d = '0;
               phase_d  = '0;
               width_d  = '0;
               sat_d    = 1'b0;
               tmo_d    = 1'b0;
            end
         end

         ST_TRIG: begin
            if (us_tick) begin
               if (phase_inc >= TRIG_W) begin
                  state_d = ST_WAIT_RISE;
                  phase_d = '0;
               end else begin
                  phase_d = phase_inc;
               end
            end
         end

         ST_WAIT_RISE: begin
            // The rise cycle is already echo-high, so a tick there counts.
            if (echo_rise) begin
               state_d = ST_MEASURE;
               width_d = us_tick ? 16'd1 : 16'd0;
               if (us_tick && (MAX_W <= 16'd1)) begin
                  width_d = MAX_W;
                  sat_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end else if (us_tick) begin
               if (phase_inc >= RISE_W) begin
                  state_d = ST_DONE;
                  tmo_d   = 1'b1;
               end else begin
                  phase_d = phase_inc;
               end
            end
         end

         ST_MEASURE: begin
            if (!echo_s2_q) begin
               state_d = ST_DONE;
            end else if (us_tick) begin
               if (width_inc >= MAX_W) begin
                  width_d = MAX_W;
                  sat_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  width_d = width_inc;
               end
            end
         end

         ST_DONE: begin
            if (!sampled_q) begin
               sampled_d     = 1'b1;
               valid_d       = 1'b1;
               echo_us_d     = width_q;
               timeout_err_d = tmo_q;
               if (opposing) begin
                  if (agree_inc >= CONFIRM_W) begin
                     too_close_d = ~too_close_q;
                     agree_d     = '0;
                  end else begin
                     agree_d = agree_inc;
                  end
               end else if (agreeing) begin
                  agree_d = '0;
               end
            end
            // A saturated echo is still high; hold here until it releases.
            if (!sat_q || !echo_s2_q) begin
               state_d   = ST_IDLE;
               sampled_d = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         echo_s1_q     <= 1'b0;
         echo_s2_q     <= 1'b0;
         echo_s3_q     <= 1'b0;
         state_q       <= ST_IDLE;
         first_q       <= 1'b1;
         period_q      <= '0;
         phase_q       <= '0;
         width_q       <= '0;
         sat_q         <= 1'b0;
         tmo_q         <= 1'b0;
         sampled_q     <= 1'b0;
         agree_q       <= '0;
         too_close_q   <= 1'b0;
         echo_us_q     <= '0;
         valid_q       <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         echo_s1_q     <= echo_s1_d;
         echo_s2_q     <= echo_s2_d;
         echo_s3_q     <= echo_s3_d;
         state_q       <= state_d;
         first_q       <= first_d;
         period_q      <= period_d;
         phase_q       <= phase_d;
         width_q       <= width_d;
         sat_q         <= sat_d;
         tmo_q         <= tmo_d;
         sampled_q     <= sampled_d;
         agree_q       <= agree_d;
         too_close_q   <= too_close_d;
         echo_us_q     <= echo_us_d;
         valid_q       <= valid_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign io.trig         = (state_q == ST_TRIG);
   assign io.tooClose     = too_close_q;
   assign io.echo_us      = echo_us_q;
   assign io.sample_valid = valid_q;
   assign io.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger at 4 MHz: scenario tasks plus randomized echo
// widths, checked against a rule-level model of range samples and debounce.
module tb_ultrasonic_ranger;

   localparam int DIV       = 4;
   localparam int TRIG_US   = 10;
   localparam int PERIOD_US = 200;
   localparam int RISE_US   = 50;
   localparam int MAX_US    = 300;
   localparam int CLOSE_US  = 40;
   localparam int CLEAR_US  = 60;
   localparam int CONFIRM   = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   ultrasonic_ranger_if io ();

   ultrasonic_ranger #(
      .CLK_HZ          (4_000_000),
      .TRIG_US         (TRIG_US),
      .PERIOD_US       (PERIOD_US),
      .RISE_TIMEOUT_US (RISE_US),
      .MAX_ECHO_US     (MAX_US),
      .CLOSE_US        (CLOSE_US),
      .CLEAR_US        (CLEAR_US),
      .CONFIRM         (CONFIRM)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   always #5 clk = ~clk;

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int last_rise = 0;
   bit gap_valid = 1'b0;
   bit m_tc      = 1'b0;
   int m_cnt     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: one range sample under the close/clear/neutral and debounce rules.
   task automatic model_sample(input int hi_us, input bit tmo, output int exp_w);
      bit close;
      bit clear;
      exp_w = tmo ? 0 : ((hi_us > MAX_US) ? MAX_US : hi_us);
      clear = tmo || (exp_w > CLEAR_US);
      close = !clear && (exp_w < CLOSE_US);
      if ((m_tc && clear) || (!m_tc && close)) begin
         m_cnt++;
         if (m_cnt == CONFIRM) begin
            m_tc  = !m_tc;
            m_cnt = 0;
         end
      end else if (clear || close) begin
         m_cnt = 0;
      end
   endtask

   task automatic model_reset();
      m_tc      = 1'b0;
      m_cnt     = 0;
      gap_valid = 1'b0;
   endtask

   task automatic release_and_first_trig(input string tag);
      int t;
      t = 0;
      rst_n = 1'b1;
      while (io.trig !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (io.trig !== 1'b1 || t > DIV) begin
         errors++;
         $display("FAIL %s_first_trig: trig=%b after %0d clk, required 1 within %0d clk", tag, io.trig, t, DIV);
      end
   endtask

   // One measurement cycle; hi_us == 0 means the echo never rises.
   task automatic run_cycle(input string tag, input int dly_us, input int hi_us, input bit drop_en);
      int t;
      int rise_at;
      int dly_clk;
      int hi_clk;
      int n_strobe;
      int got_w;
      bit got_t;
      bit got_tc;
      bit early_trig;
      bit tmo;
      int exp_w;
      int end_us;
      tmo = (hi_us == 0);
      t = 0;
      while (io.trig !== 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (io.trig !== 1'b1) begin
         errors++;
         $display("FAIL %s_trig_start: trig=%b, required 1 within 3000 clk", tag, io.trig);
         return;
      end
      rise_at = cyc;
      if (gap_valid) begin
         checks++;
         if (rise_at - last_rise !== PERIOD_US * DIV) begin
            errors++;
            $display("FAIL %s_period: %0d clk between triggers, required %0d", tag, rise_at - last_rise, PERIOD_US * DIV);
         end
      end
      last_rise = rise_at;
      end_us    = tmo ? RISE_US : dly_us + hi_us;
      gap_valid = (TRIG_US + end_us + 5 < PERIOD_US) && !drop_en;

      t = 0;
      while (io.trig === 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t !== TRIG_US * DIV) begin
         errors++;
         $display("FAIL %s_trig_width: trig high %0d clk, required %0d", tag, t, TRIG_US * DIV);
      end
      if (drop_en) io.enable = 1'b0;

      dly_clk    = dly_us * DIV;
      hi_clk     = hi_us * DIV;
      n_strobe   = 0;
      early_trig = 1'b0;
      got_w      = 0;
      got_t      = 1'b0;
      got_tc     = 1'b0;
      for (int i = 0; i < 4000 && !(n_strobe > 0 && i >= dly_clk + hi_clk); i++) begin
         io.echo = (i >= dly_clk) && (i < dly_clk + hi_clk);
         @(negedge clk);
         if (io.trig === 1'b1) early_trig = 1'b1;
         if (io.sample_valid === 1'b1) begin
            n_strobe++;
            got_w  = int'(io.echo_us);
            got_t  = io.timeout_err;
            got_tc = io.tooClose;
         end
      end
      io.echo = 1'b0;

      model_sample(hi_us, tmo, exp_w);
      checks++;
      if (early_trig) begin
         errors++;
         $display("FAIL %s_no_retrig: trig rose before the echo/sample finished, required 0", tag);
      end
      checks++;
      if (n_strobe !== 1) begin
         errors++;
         $display("FAIL %s_strobe: %0d sample_valid pulses, required 1", tag, n_strobe);
      end else begin
         checks++;
         if (got_w !== exp_w) begin
            errors++;
            $display("FAIL %s_echo_us: got %0d, required %0d", tag, got_w, exp_w);
         end
         checks++;
         if (got_t !== tmo) begin
            errors++;
            $display("FAIL %s_timeout_err: got %b, required %b", tag, got_t, tmo);
         end
         checks++;
         if (got_tc !== m_tc) begin
            errors++;
            $display("FAIL %s_tooClose: got %b, required %b", tag, got_tc, m_tc);
         end
      end
   endtask

   task automatic test_reset();
      io.enable = 1'b1;
      io.echo   = 1'b0;
      rst_n     = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if ({io.trig, io.tooClose, io.sample_valid, io.timeout_err, io.echo_us} !== 20'd0) begin
         errors++;
         $display("FAIL reset_state: trig=%b tooClose=%b valid=%b tmo=%b echo_us=%0d, required all 0",
                  io.trig, io.tooClose, io.sample_valid, io.timeout_err, io.echo_us);
      end
      model_reset();
      release_and_first_trig("reset");
   endtask

   task automatic test_timeout();
      run_cycle("timeout0", 0, 0, 1'b0);
      run_cycle("timeout1", 0, 0, 1'b0);
   endtask

   task automatic test_close_confirm();
      run_cycle("close0", 4, 30, 1'b0);
      run_cycle("close1", 7, 30, 1'b0);
   endtask

   task automatic test_hysteresis();
      for (int i = 0; i < 3; i++) run_cycle("neutral", 3 + i, 50, 1'b0);
      run_cycle("clear0", 6, 70, 1'b0);
      run_cycle("clear1", 2, 70, 1'b0);
   endtask

   task automatic test_saturation();
      run_cycle("saturate", 5, 400, 1'b0);
      run_cycle("after_sat", 5, 45, 1'b0);
   endtask

   task automatic test_alternating();
      for (int i = 0; i < 6; i++) run_cycle("alternate", 1 + i, (i % 2 == 0) ? 30 : 70, 1'b0);
   endtask

   task automatic test_random();
      int hi;
      int r;
      for (int n = 0; n < 20; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) hi = 0;
         else if (r == 1) hi = 300 + $urandom_range(0, 60);
         else if (r <= 3) begin
            case ($urandom_range(0, 3))
               0: hi = CLOSE_US - 1;
               1: hi = CLOSE_US;
               2: hi = CLEAR_US;
               default: hi = CLEAR_US + 1;
            endcase
         end else hi = $urandom_range(1, 120);
         run_cycle("random", $urandom_range(1, 20), hi, 1'b0);
      end
   endtask

   task automatic test_enable();
      int t;
      bit saw_trig;
      bit tc_moved;
      run_cycle("en_drop0", 3, 25, 1'b0);
      run_cycle("en_drop1", 5, 25, 1'b1);
      saw_trig = 1'b0;
      tc_moved = 1'b0;
      repeat (1200) begin
         @(negedge clk);
         if (io.trig === 1'b1) saw_trig = 1'b1;
         if (io.tooClose !== m_tc) tc_moved = 1'b1;
      end
      checks++;
      if (saw_trig) begin
         errors++;
         $display("FAIL enable_idle: trig rose while enable=0, required no trigger");
      end
      checks++;
      if (tc_moved) begin
         errors++;
         $display("FAIL enable_hold: tooClose changed while idle, required hold at %b", m_tc);
      end
      io.enable = 1'b1;
      gap_valid = 1'b0;
      t = 0;
      while (io.trig !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (io.trig !== 1'b1 || t > DIV) begin
         errors++;
         $display("FAIL enable_resume: trig=%b after %0d clk, required 1 within %0d clk", io.trig, t, DIV);
      end
   endtask

   task automatic test_reset_mid();
      int t;
      t = 0;
      while (io.trig !== 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({io.trig, io.tooClose, io.sample_valid, io.timeout_err, io.echo_us} !== 20'd0) begin
         errors++;
         $display("FAIL reset_mid_trig: trig=%b tooClose=%b valid=%b tmo=%b echo_us=%0d, required all 0",
                  io.trig, io.tooClose, io.sample_valid, io.timeout_err, io.echo_us);
      end
      model_reset();
      @(negedge clk);
      release_and_first_trig("mid_trig");
      run_cycle("pre_measure0", 4, 20, 1'b0);
      run_cycle("pre_measure1", 4, 20, 1'b0);

      t = 0;
      while (io.trig !== 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      t = 0;
      while (io.trig === 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      repeat (8) @(negedge clk);
      io.echo = 1'b1;
      repeat (200) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({io.trig, io.tooClose, io.sample_valid, io.timeout_err, io.echo_us} !== 20'd0) begin
         errors++;
         $display("FAIL reset_mid_measure: trig=%b tooClose=%b valid=%b tmo=%b echo_us=%0d, required all 0",
                  io.trig, io.tooClose, io.sample_valid, io.timeout_err, io.echo_us);
      end
      io.echo = 1'b0;
      model_reset();
      @(negedge clk);
      release_and_first_trig("mid_measure");
      run_cycle("post_reset", 5, 30, 1'b0);
   endtask

   initial begin
      io.enable = 1'b0;
      io.echo   = 1'b0;
      test_reset();
      test_timeout();
      test_close_confirm();
      test_hysteresis();
      test_saturation();
      test_alternating();
      test_random();
      test_enable();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
